// File: rtl/command_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module : command_accumulator_pkg
// Brief  : Shared state encoding, command indices and default widths for the
//          command accumulator.
// Rev    : 1.0  initial release
// ============================================================================
package command_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        TOTAL = 2'd2,
        ERROR = 2'd3
    } state_t;

    // Bit positions of each strobe in the packed command vector
    localparam int c_CMD_ENTER  = 0;
    localparam int c_CMD_NUMBER = 1;
    localparam int c_CMD_TOTAL  = 2;
    localparam int c_CMD_CLEAR  = 3;
    localparam int c_NUM_CMDS   = 4;

    localparam int c_DEFAULT_DATA_W    = 8;
    localparam int c_DEFAULT_ACC_W     = 16;
    localparam int c_DEFAULT_MAX_ITEMS = 15;

endpackage
`default_nettype wire

// File: rtl/command_accumulator_cmd_edge_detect.sv
`default_nettype none
// ============================================================================
// Module : cmd_edge_detect
// Brief  : Rising-edge detector for the four command strobes, with a flag
//          for more than one edge in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
module cmd_edge_detect
    import command_accumulator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [c_NUM_CMDS-1:0] i_cmdLevel,
    output logic [c_NUM_CMDS-1:0] o_cmdEdge,
    output logic                  o_multiEdge
);

    logic [c_NUM_CMDS-1:0] r_prev;
    logic                  r_armed;

    // The first clock after reset only captures the levels, so a strobe held
    // through reset must drop and rise again before it acts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_cmdLevel;
            r_armed <= 1'b1;
        end
    end

    assign o_cmdEdge   = r_armed ? (i_cmdLevel & ~r_prev) : '0;
    assign o_multiEdge = ($countones(o_cmdEdge) > 1);

endmodule
`default_nettype wire

// File: rtl/command_accumulator.sv
`default_nettype none
// ============================================================================
// Module : command_accumulator
// Brief  : Turns decoded front-panel command strobes into a saturating
//          running sum with item count, total mode and sticky flags.
// Rev    : 1.0  initial release
// ============================================================================
module command_accumulator
    import command_accumulator_pkg::*;
#(
    parameter int DATA_W    = c_DEFAULT_DATA_W,
    parameter int ACC_W     = c_DEFAULT_ACC_W,
    parameter int MAX_ITEMS = c_DEFAULT_MAX_ITEMS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enter_cmd,
    input  logic              number_cmd,
    input  logic              total_cmd,
    input  logic              clear_cmd,
    input  logic              cmd_err,
    input  logic [DATA_W-1:0] number_in,
    output logic [ACC_W-1:0]  acc_out,
    output logic [3:0]        item_count,
    output logic              pending_valid,
    output logic              total_valid,
    output logic              overflow,
    output logic              err_flag,
    output logic [1:0]        state_out
);

    logic [c_NUM_CMDS-1:0] w_cmdLevel;
    logic [c_NUM_CMDS-1:0] w_edge;
    logic                  w_multiEdge;
    logic [ACC_W:0]        w_sum;

    state_t                r_state;
    logic [ACC_W-1:0]      r_acc;
    logic [3:0]            r_itemCount;
    logic [DATA_W-1:0]     r_pending;
    logic                  r_pendingValid;
    logic                  r_totalValid;
    logic                  r_overflow;
    logic                  r_errFlag;

    always_comb begin
        w_cmdLevel               = '0;
        w_cmdLevel[c_CMD_ENTER]  = enter_cmd;
        w_cmdLevel[c_CMD_NUMBER] = number_cmd;
        w_cmdLevel[c_CMD_TOTAL]  = total_cmd;
        w_cmdLevel[c_CMD_CLEAR]  = clear_cmd;
    end

    cmd_edge_detect u_edgeDetect (
        .clk         (clk),
        .rst         (rst),
        .i_cmdLevel  (w_cmdLevel),
        .o_cmdEdge   (w_edge),
        .o_multiEdge (w_multiEdge)
    );

    // One extra bit catches the carry used for saturation
    assign w_sum = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_pending);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_acc          <= '0;
            r_itemCount    <= '0;
            r_pending      <= '0;
            r_pendingValid <= 1'b0;
            r_totalValid   <= 1'b0;
            r_overflow     <= 1'b0;
            r_errFlag      <= 1'b0;
        end else if (cmd_err || w_multiEdge) begin
            r_state      <= ERROR;
            r_errFlag    <= 1'b1;
            r_totalValid <= 1'b0;
        end else if (w_edge[c_CMD_CLEAR]) begin
            r_state        <= IDLE;
            r_acc          <= '0;
            r_itemCount    <= '0;
            r_pendingValid <= 1'b0;
            r_totalValid   <= 1'b0;
            r_overflow     <= 1'b0;
            r_errFlag      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_edge[c_CMD_NUMBER]) begin
                        r_pending      <= number_in;
                        r_pendingValid <= 1'b1;
                    end else if (w_edge[c_CMD_ENTER] && r_pendingValid) begin
                        if (r_itemCount == 4'(MAX_ITEMS)) begin
                            r_state   <= ERROR;
                            r_errFlag <= 1'b1;
                        end else begin
                            r_itemCount    <= r_itemCount + 4'd1;
                            r_pendingValid <= 1'b0;
                            if (w_sum[ACC_W]) begin
                                r_acc      <= '1;
                                r_overflow <= 1'b1;
                                r_errFlag  <= 1'b1;
                                r_state    <= ERROR;
                            end else begin
                                r_acc   <= w_sum[ACC_W-1:0];
                                r_state <= ACCUM;
                            end
                        end
                    end else if (w_edge[c_CMD_TOTAL]) begin
                        r_totalValid   <= 1'b1;
                        r_pendingValid <= 1'b0;
                        r_state        <= TOTAL;
                    end
                end
                TOTAL: begin
                    if (w_edge[c_CMD_NUMBER] || w_edge[c_CMD_ENTER]) begin
                        r_errFlag    <= 1'b1;
                        r_totalValid <= 1'b0;
                        r_state      <= ERROR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc_out       = r_acc;
    assign item_count    = r_itemCount;
    assign pending_valid = r_pendingValid;
    assign total_valid   = r_totalValid;
    assign overflow      = r_overflow;
    assign err_flag      = r_errFlag;
    assign state_out     = r_state;

endmodule
`default_nettype wire
